// File: rtl/sipo_rx.sv
// ---------------------------------------------------------------------------
// sipo_rx -- serial-in / parallel-out UART receiver.
//
// Samples the asynchronous serial line on a 16x oversampling tick clock
// (BaudOut). A frame is: start bit (0), 7 or 8 data bits LSB first,
// optional parity bit, one or two stop bits (1). The frame format is
// latched at the start edge so config changes mid-frame have no effect.
//
// Ports:
//   BaudOut      in   16x oversampling tick clock, rising edge active
//   Reset        in   asynchronous active-high reset
//   DataIn       in   serial line, idle high
//   StopBits     in   0 = one stop bit, 1 = two stop bits
//   DataLength   in   0 = 7 data bits, 1 = 8 data bits
//   ParityType   in   00/11 = none, 01 = odd, 10 = even
//   DataParl     out  received byte (bit 7 is 0 in 7-bit mode)
//   ParityError  out  parity mismatch of the last frame (0 if no parity)
//   StopError    out  a sampled stop bit was 0 in the last frame
//   ActiveFlag   out  high while a frame is being received
//   DoneFlag     out  one-cycle pulse when a frame completes
//   o_dbg_state  out  current FSM state encoding, for observation only
//
// Timing: with cycle 0 the first IDLE cycle that sees the synchronized
// line low, bit k is sampled in cycle 8+16k-1 and DoneFlag (together with
// the new DataParl/ParityError/StopError) is visible two cycles after the
// last stop-bit sample.
// ---------------------------------------------------------------------------
module sipo_rx (
  input  logic       BaudOut,
  input  logic       Reset,
  input  logic       DataIn,
  input  logic       StopBits,
  input  logic       DataLength,
  input  logic [1:0] ParityType,
  output logic [7:0] DataParl,
  output logic       ParityError,
  output logic       StopError,
  output logic       ActiveFlag,
  output logic       DoneFlag,
  output logic [2:0] o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  logic       r_sync1;
  logic       r_sync2;
  state_t     r_state;
  logic [3:0] r_tick;
  logic [2:0] r_bit_idx;
  logic       r_stop_idx;
  logic       r_armed;

  // Frame format latched at the start edge.
  logic       r_cfg_stop2;
  logic       r_cfg_len8;
  logic [1:0] r_cfg_par;

  // Per-frame accumulation.
  logic [7:0] r_shift;
  logic       r_par_acc;
  logic       r_par_err_pend;
  logic       r_stop_err_pend;

  // Registered outputs.
  logic [7:0] r_data_out;
  logic       r_par_err;
  logic       r_stop_err;
  logic       r_done;

  // -------------------------------------------------------------------------
  // Wires
  // -------------------------------------------------------------------------
  logic       w_rx;
  state_t     w_state_next;
  logic [3:0] w_tick_next;
  logic [2:0] w_bit_idx_next;
  logic       w_stop_idx_next;
  logic       w_tick_end;
  logic       w_par_en;
  logic [2:0] w_last_idx;
  logic       w_start_det;
  logic       w_shift_en;
  logic       w_par_smp;
  logic       w_stop_smp;
  logic       w_load_out;

  // -------------------------------------------------------------------------
  // Two-flop synchronizer; resets to the idle (high) line level.
  // -------------------------------------------------------------------------
  always_ff @(posedge BaudOut or posedge Reset) begin
    if (Reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= DataIn;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx       = r_sync2;
  assign w_tick_end = (r_tick == 4'd15);
  assign w_par_en   = (r_cfg_par == 2'b01) || (r_cfg_par == 2'b10);
  assign w_last_idx = r_cfg_len8 ? 3'd7 : 3'd6;

  // -------------------------------------------------------------------------
  // FSM state register and bit-timing counters
  // -------------------------------------------------------------------------
  always_ff @(posedge BaudOut or posedge Reset) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_tick     <= 4'd0;
      r_bit_idx  <= 3'd0;
      r_stop_idx <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_tick     <= w_tick_next;
      r_bit_idx  <= w_bit_idx_next;
      r_stop_idx <= w_stop_idx_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next-state and sample strobes
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next    = r_state;
    w_tick_next     = r_tick;
    w_bit_idx_next  = r_bit_idx;
    w_stop_idx_next = r_stop_idx;
    w_start_det     = 1'b0;
    w_shift_en      = 1'b0;
    w_par_smp       = 1'b0;
    w_stop_smp      = 1'b0;
    w_load_out      = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_tick_next     = 4'd0;
        w_bit_idx_next  = 3'd0;
        w_stop_idx_next = 1'b0;
        // Only a line that has been seen high can start a frame, so a
        // held-low line (break) produces a single frame.
        if (!w_rx && r_armed) begin
          w_start_det  = 1'b1;
          w_state_next = S_START;
          // The detection cycle itself is tick 0 of the start bit, so the
          // counter enters START already at 1 and hits 7 at the bit centre.
          w_tick_next  = 4'd1;
        end
      end

      S_START: begin
        if (r_tick == 4'd7) begin
          w_tick_next  = 4'd0;
          // A line back high at the centre of the start bit is a glitch.
          w_state_next = w_rx ? S_IDLE : S_DATA;
        end else begin
          w_tick_next = r_tick + 4'd1;
        end
      end

      S_DATA: begin
        w_tick_next = r_tick + 4'd1;
        if (w_tick_end) begin
          w_shift_en = 1'b1;
          if (r_bit_idx == w_last_idx) begin
            w_bit_idx_next = 3'd0;
            w_state_next   = w_par_en ? S_PARITY : S_STOP;
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
          end
        end
      end

      S_PARITY: begin
        w_tick_next = r_tick + 4'd1;
        if (w_tick_end) begin
          w_par_smp       = 1'b1;
          w_stop_idx_next = 1'b0;
          w_state_next    = S_STOP;
        end
      end

      S_STOP: begin
        w_tick_next = r_tick + 4'd1;
        if (w_tick_end) begin
          w_stop_smp = 1'b1;
          if (r_cfg_stop2 && !r_stop_idx) begin
            w_stop_idx_next = 1'b1;
          end else begin
            w_stop_idx_next = 1'b0;
            w_state_next    = S_DONE;
          end
        end
      end

      S_DONE: begin
        w_load_out   = 1'b1;
        w_tick_next  = 4'd0;
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
        w_tick_next  = 4'd0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Re-arm tracking: set by any high line level, consumed by a start.
  // -------------------------------------------------------------------------
  always_ff @(posedge BaudOut or posedge Reset) begin
    if (Reset) begin
      r_armed <= 1'b0;
    end else if (w_rx) begin
      r_armed <= 1'b1;
    end else if (w_start_det) begin
      r_armed <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Frame format latch
  // -------------------------------------------------------------------------
  always_ff @(posedge BaudOut or posedge Reset) begin
    if (Reset) begin
      r_cfg_stop2 <= 1'b0;
      r_cfg_len8  <= 1'b0;
      r_cfg_par   <= 2'b00;
    end else if (w_start_det) begin
      r_cfg_stop2 <= StopBits;
      r_cfg_len8  <= DataLength;
      r_cfg_par   <= ParityType;
    end
  end

  // -------------------------------------------------------------------------
  // Data shift, running parity and error accumulation
  // -------------------------------------------------------------------------
  always_ff @(posedge BaudOut or posedge Reset) begin
    if (Reset) begin
      r_shift         <= 8'h00;
      r_par_acc       <= 1'b0;
      r_par_err_pend  <= 1'b0;
      r_stop_err_pend <= 1'b0;
    end else if (w_start_det) begin
      // Cleared per frame so bit 7 stays 0 when only 7 bits are shifted.
      r_shift         <= 8'h00;
      r_par_acc       <= 1'b0;
      r_par_err_pend  <= 1'b0;
      r_stop_err_pend <= 1'b0;
    end else begin
      if (w_shift_en) begin
        r_shift[r_bit_idx] <= w_rx;
        r_par_acc          <= r_par_acc ^ w_rx;
      end
      // XOR over data and parity bit is 1 for a correct odd frame and 0
      // for a correct even frame; ParityType[0] is 1 only for odd.
      if (w_par_smp) begin
        r_par_err_pend <= r_par_acc ^ w_rx ^ r_cfg_par[0];
      end
      if (w_stop_smp && !w_rx) begin
        r_stop_err_pend <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output registers: all results update together with the DoneFlag pulse
  // and hold until the next completed frame.
  // -------------------------------------------------------------------------
  always_ff @(posedge BaudOut or posedge Reset) begin
    if (Reset) begin
      r_data_out <= 8'h00;
      r_par_err  <= 1'b0;
      r_stop_err <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_load_out;
      if (w_load_out) begin
        r_data_out <= {r_shift[7] & r_cfg_len8, r_shift[6:0]};
        r_par_err  <= r_par_err_pend;
        r_stop_err <= r_stop_err_pend;
      end
    end
  end

  assign DataParl    = r_data_out;
  assign ParityError = r_par_err;
  assign StopError   = r_stop_err;
  assign DoneFlag    = r_done;
  assign ActiveFlag  = (r_state == S_START)  || (r_state == S_DATA) ||
                       (r_state == S_PARITY) || (r_state == S_STOP);
  assign o_dbg_state = r_state;

endmodule
